// File: rtl/regs_sb.sv
// Integer register file with same-cycle write bypass and a write-back scoreboard
// that stalls decode on RAW/WAW hazards against issued-but-unwritten destinations.
module regs_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] reg_wdata_i,
  input  logic [AW-1:0]   reg_waddr_i,
  input  logic            reg_wen_i,
  input  logic [AW-1:0]   rs1_raddr_i,
  input  logic [AW-1:0]   rs2_raddr_i,
  output logic [XLEN-1:0] rs1_rdata_o,
  output logic [XLEN-1:0] rs2_rdata_o,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            issue_wen_i,
  output logic            stall_o,
  output logic [AW:0]     busy_cnt_o,
  input  logic [AW-1:0]   dbg_raddr_i,
  output logic [XLEN-1:0] dbg_rdata_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            wr_en, haz1, haz2, waw, accept, set_en, set_new, clr_old;

  assign wr_en = reg_wen_i && (reg_waddr_i != '0);

  assign rs1_rdata_o = (rs1_raddr_i == '0) ? '0 :
                       (wr_en && reg_waddr_i == rs1_raddr_i) ? reg_wdata_i :
                       regs_q[rs1_raddr_i];
  assign rs2_rdata_o = (rs2_raddr_i == '0) ? '0 :
                       (wr_en && reg_waddr_i == rs2_raddr_i) ? reg_wdata_i :
                       regs_q[rs2_raddr_i];
  assign dbg_rdata_o = (dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];

  // A write-back landing this cycle resolves the hazard on that register.
  assign haz1 = busy_q[rs1_raddr_i] && (rs1_raddr_i != '0) &&
                !(wr_en && reg_waddr_i == rs1_raddr_i);
  assign haz2 = busy_q[rs2_raddr_i] && (rs2_raddr_i != '0) &&
                !(wr_en && reg_waddr_i == rs2_raddr_i);
  assign waw  = issue_wen_i && (issue_rd_i != '0) && busy_q[issue_rd_i] &&
                !(wr_en && reg_waddr_i == issue_rd_i);

  assign stall_o = issue_valid_i && (haz1 || haz2 || waw);
  assign accept  = issue_valid_i && !stall_o;
  assign set_en  = accept && issue_wen_i && (issue_rd_i != '0);

  // Set is applied after clear so the younger issuing instruction wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[reg_waddr_i] = 1'b0;
    if (set_en) busy_d[issue_rd_i]  = 1'b1;
  end

  assign set_new = set_en && !busy_q[issue_rd_i];
  assign clr_old = wr_en && busy_q[reg_waddr_i] &&
                   !(set_en && issue_rd_i == reg_waddr_i);

  always_comb begin
    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_old};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[reg_waddr_i] <= reg_wdata_i;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb: directed test-plan steps followed by random
// traffic, all checked against an array-based register/scoreboard model.
module tb_regs_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] reg_wdata_i;
  logic [AW-1:0]   reg_waddr_i;
  logic            reg_wen_i;
  logic [AW-1:0]   rs1_raddr_i, rs2_raddr_i;
  logic [XLEN-1:0] rs1_rdata_o, rs2_rdata_o;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            issue_wen_i;
  logic            stall_o;
  logic [AW:0]     busy_cnt_o;
  logic [AW-1:0]   dbg_raddr_i;
  logic [XLEN-1:0] dbg_rdata_o;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] mRegs [NREG];
  bit              mBusy [NREG];

  always #5 clk = ~clk;

  regs_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .reg_wdata_i(reg_wdata_i), .reg_waddr_i(reg_waddr_i), .reg_wen_i(reg_wen_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i),
    .rs1_rdata_o(rs1_rdata_o), .rs2_rdata_o(rs2_rdata_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_wen_i(issue_wen_i),
    .stall_o(stall_o), .busy_cnt_o(busy_cnt_o),
    .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o)
  );

  function automatic logic [XLEN-1:0] expRead(input int a, input bit bypass);
    if (a == 0) return '0;
    if (bypass && reg_wen_i && int'(reg_waddr_i) == a) return reg_wdata_i;
    return mRegs[a];
  endfunction

  // A register blocks decode if it awaits a result not arriving this cycle.
  function automatic bit pending(input int a);
    return a != 0 && mBusy[a] && !(reg_wen_i && int'(reg_waddr_i) == a);
  endfunction

  function automatic bit expStall();
    return issue_valid_i && (pending(int'(rs1_raddr_i)) || pending(int'(rs2_raddr_i)) ||
                             (issue_wen_i && pending(int'(issue_rd_i))));
  endfunction

  function automatic int busyCount();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/rs1"},   rs1_rdata_o, expRead(int'(rs1_raddr_i), 1'b1));
    checkVal({tag, "/rs2"},   rs2_rdata_o, expRead(int'(rs2_raddr_i), 1'b1));
    checkVal({tag, "/dbg"},   dbg_rdata_o, expRead(int'(dbg_raddr_i), 1'b0));
    checkVal({tag, "/stall"}, {31'b0, stall_o}, {31'b0, expStall()});
    checkVal({tag, "/cnt"},   {26'b0, busy_cnt_o}, busyCount());
  endtask

  // Called at a negedge; inputs then settle for 1 time unit before checks.
  task automatic applyStimulus(input bit r, input bit wen, input int waddr, input logic [31:0] wdata,
                               input int rs1, input int rs2, input bit iv, input int rd,
                               input bit iwen, input int dbg);
    rst = r; reg_wen_i = wen; reg_waddr_i = AW'(waddr); reg_wdata_i = wdata;
    rs1_raddr_i = AW'(rs1); rs2_raddr_i = AW'(rs2);
    issue_valid_i = iv; issue_rd_i = AW'(rd); issue_wen_i = iwen; dbg_raddr_i = AW'(dbg);
    #1;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin mRegs[i] = '0; mBusy[i] = 1'b0; end
    end else begin
      acc = issue_valid_i && !expStall();
      if (reg_wen_i && reg_waddr_i != 0) begin
        mRegs[reg_waddr_i] = reg_wdata_i;
        mBusy[reg_waddr_i] = 1'b0;
      end
      if (acc && issue_wen_i && issue_rd_i != 0) mBusy[issue_rd_i] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin mRegs[i] = 'x; mBusy[i] = 1'b0; end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Reset state
    applyStimulus(0, 0, 0, 0, 1, 31, 1, 2, 1, 17);
    checkOutput("reset");
    checkVal("reset/dbg17", dbg_rdata_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 1: basic write, x0 write dropped
    applyStimulus(0, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 32'hFFFF_FFFF, 5, 0, 0, 0, 0, 0);
    checkOutput("t1a");
    checkVal("t1/rs1_x5", rs1_rdata_o, 32'h1234);
    tick();
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    checkVal("t1/rs2_x0", rs2_rdata_o, 32'h0);
    checkVal("t1/dbg_x0", dbg_rdata_o, 32'h0);

    // 2: bypass
    applyStimulus(0, 1, 7, 32'h11, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 7, 32'h22, 7, 7, 0, 0, 0, 7);
    checkOutput("t2a");
    checkVal("t2/rs1_byp", rs1_rdata_o, 32'h22);
    checkVal("t2/rs2_byp", rs2_rdata_o, 32'h22);
    checkVal("t2/dbg_old", dbg_rdata_o, 32'h11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    checkVal("t2/dbg_new", dbg_rdata_o, 32'h22);

    // 3: RAW on x3
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    checkVal("t3/iss_stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    checkVal("t3/cnt1", {26'b0, busy_cnt_o}, 32'd1);
    checkVal("t3/raw_stall", {31'b0, stall_o}, 32'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    checkVal("t3/raw_stall2", {31'b0, stall_o}, 32'h1);
    tick();
    applyStimulus(0, 1, 3, 32'hAB, 3, 0, 1, 0, 0, 0);
    checkOutput("t3wb");
    checkVal("t3/wb_stall", {31'b0, stall_o}, 32'h0);
    checkVal("t3/wb_rs1", rs1_rdata_o, 32'hAB);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t3/cnt0", {26'b0, busy_cnt_o}, 32'd0);

    // 4: WAW on x9, set wins over same-cycle clear
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 1, 0);
    checkVal("t4/waw_stall", {31'b0, stall_o}, 32'h1);
    checkVal("t4/cnt1", {26'b0, busy_cnt_o}, 32'd1);
    tick();
    applyStimulus(0, 1, 9, 32'h99, 0, 0, 1, 9, 1, 0);
    checkOutput("t4wb");
    checkVal("t4/wb_stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
    checkVal("t4/cnt_hold", {26'b0, busy_cnt_o}, 32'd1);
    checkVal("t4/still_busy", {31'b0, stall_o}, 32'h1);
    applyStimulus(0, 1, 9, 32'h9A, 0, 0, 0, 0, 0, 0);
    tick();

    // 5: reset mid-operation
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("t5/cnt2", {26'b0, busy_cnt_o}, 32'd2);
    applyStimulus(1, 1, 4, 32'h55, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 4, 5, 1, 0, 0, 4);
    checkOutput("t5post");
    checkVal("t5/stall", {31'b0, stall_o}, 32'h0);
    checkVal("t5/cnt0", {26'b0, busy_cnt_o}, 32'd0);
    checkVal("t5/rs2_x5", rs2_rdata_o, 32'h0);
    checkVal("t5/dbg_x4", dbg_rdata_o, 32'h0);
    tick();

    // 6: x0 as destination
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkVal("t6/stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkVal("t6/stall_rs0", {31'b0, stall_o}, 32'h0);
    checkVal("t6/cnt0", {26'b0, busy_cnt_o}, 32'd0);
    tick();

    // Fill every destination: counter tops out at NREG-1
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, i, 1, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("full/cnt", {26'b0, busy_cnt_o}, NREG - 1);
    for (int i = 1; i < NREG; i++) begin
      applyStimulus(0, 1, i, $urandom, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("drain/cnt", {26'b0, busy_cnt_o}, 32'd0);

    // Random traffic; mostly low addresses so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      int a[5];
      for (int k = 0; k < 5; k++)
        a[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1))
                                            : int'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), a[0], $urandom,
                    a[1], a[2], $urandom_range(0, 1), a[3], $urandom_range(0, 3) != 0, a[4]);
      checkOutput("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
